// File: rtl/fractal_sync_pkg.sv
// Shared helpers for the fractal sync node: port kinds and index-width sizing.
package fractal_sync_pkg;

  typedef enum logic [1:0] {
    PORT_RX     = 2'd0,
    PORT_LOCAL  = 2'd1,
    PORT_REMOTE = 2'd2
  } fs_port_e;

  // Width of an index into n ports, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fractal_sync_rr_scan.sv
// One round-robin scan stage: first set request at or after i_start (circular),
// returned one-hot, plus the requests left for the next stage.
module fractal_sync_rr_scan import fractal_sync_pkg::*; #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic [N-1:0]     o_gnt,
  output logic [N-1:0]     o_rem
);

  int  j;
  logic found;

  always_comb begin
    o_gnt = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < int'(N); k++) begin
      j = (int'(i_start) + k) % int'(N);
      if (!found && i_req[j]) begin
        o_gnt[j] = 1'b1;
        found    = 1'b1;
      end
    end
    o_rem = i_req & ~o_gnt;
  end

endmodule

// File: rtl/fractal_sync_mg_rr_arbiter.sv
// Multi-grant round-robin arbiter: pops up to OUT_PORTS FIFO heads per cycle in
// circular order from a rotating pointer and presents them on registered lanes.
module fractal_sync_mg_rr_arbiter import fractal_sync_pkg::*; #(
  parameter int unsigned IN_PORTS  = 4,
  parameter int unsigned OUT_PORTS = 2,
  parameter type         arbiter_t = logic,
  localparam int unsigned IDX_W    = idx_width(IN_PORTS)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic     [IN_PORTS-1:0]             empty_i,
  input  arbiter_t [IN_PORTS-1:0]             element_i,
  output logic     [IN_PORTS-1:0]             pop_o,
  output arbiter_t [OUT_PORTS-1:0]            element_o,
  output logic     [OUT_PORTS-1:0]            valid_o,
  output logic     [OUT_PORTS-1:0][IDX_W-1:0] grant_idx_o,
  output logic     [IDX_W-1:0]                prio_o
);

  if (IN_PORTS < OUT_PORTS || OUT_PORTS == 0) begin : g_bad_cfg
    $fatal(1, "fractal_sync_mg_rr_arbiter: need IN_PORTS >= OUT_PORTS >= 1");
  end

  logic [IDX_W-1:0]                r_prio;
  logic [OUT_PORTS-1:0]            r_valid;
  arbiter_t [OUT_PORTS-1:0]        r_elem;
  logic [OUT_PORTS-1:0][IDX_W-1:0] r_gidx;

  logic [OUT_PORTS:0][IN_PORTS-1:0]  w_req;
  logic [OUT_PORTS-1:0][IN_PORTS-1:0] w_gnt;
  logic [OUT_PORTS-1:0]              w_lane_vld;
  logic [OUT_PORTS-1:0][IDX_W-1:0]   w_lane_idx;
  logic [IN_PORTS-1:0]               w_pop;
  logic [IDX_W-1:0]                  w_prio_nxt;

  assign w_req[0] = ~empty_i;

  // Every stage scans from the same pointer; masking earlier grants keeps scan order.
  for (genvar k = 0; k < int'(OUT_PORTS); k++) begin : g_stage
    fractal_sync_rr_scan #(.N(IN_PORTS), .IDX_W(IDX_W)) u_scan (
      .i_req   (w_req[k]),
      .i_start (r_prio),
      .o_gnt   (w_gnt[k]),
      .o_rem   (w_req[k+1])
    );
  end

  always_comb begin
    w_pop      = '0;
    w_lane_vld = '0;
    w_lane_idx = '0;
    w_prio_nxt = r_prio;
    for (int k = 0; k < int'(OUT_PORTS); k++) begin
      w_pop         = w_pop | w_gnt[k];
      w_lane_vld[k] = |w_gnt[k];
      for (int i = 0; i < int'(IN_PORTS); i++)
        if (w_gnt[k][i]) w_lane_idx[k] = IDX_W'(i);
      if (w_lane_vld[k])
        w_prio_nxt = (w_lane_idx[k] == IDX_W'(IN_PORTS - 1)) ? '0 : w_lane_idx[k] + 1'b1;
    end
  end

  assign pop_o = rst_i ? '0 : w_pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prio  <= '0;
      r_valid <= '0;
      r_elem  <= '0;
      r_gidx  <= '0;
    end else begin
      r_prio  <= w_prio_nxt;
      r_valid <= w_lane_vld;
      for (int k = 0; k < int'(OUT_PORTS); k++) begin
        r_elem[k] <= w_lane_vld[k] ? element_i[w_lane_idx[k]] : '0;
        r_gidx[k] <= w_lane_vld[k] ? w_lane_idx[k] : '0;
      end
    end
  end

  assign valid_o     = r_valid;
  assign element_o   = r_elem;
  assign grant_idx_o = r_gidx;
  assign prio_o      = r_prio;

endmodule

// File: tb/tb_fractal_sync_mg_rr_arbiter.sv
// Bench for the multi-grant round-robin arbiter (4 inputs, 2 lanes, byte elements).
module tb_fractal_sync_mg_rr_arbiter;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic [3:0]           empty_i = 4'hF;
  logic [3:0][7:0]      element_i = '0;
  logic [3:0]           pop_o;
  logic [1:0][7:0]      element_o;
  logic [1:0]           valid_o;
  logic [1:0][1:0]      grant_idx_o;
  logic [1:0]           prio_o;

  always #5 clk_i = ~clk_i;

  fractal_sync_mg_rr_arbiter #(.IN_PORTS(4), .OUT_PORTS(2), .arbiter_t(logic [7:0])) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .empty_i     (empty_i),
    .element_i   (element_i),
    .pop_o       (pop_o),
    .element_o   (element_o),
    .valid_o     (valid_o),
    .grant_idx_o (grant_idx_o),
    .prio_o      (prio_o)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] empty;
    logic [3:0] pop;
    logic [1:0] valid;
    logic [1:0] i0;
    logic [1:0] i1;
    logic [1:0] prio;
  } vec_t;

  typedef struct packed {
    logic [1:0]      valid;
    logic [1:0][1:0] idx;
    logic [1:0][7:0] elem;
    logic [1:0]      prio;
  } exp_t;

  exp_t       sb_q[$];
  int         n_pass = 0;
  int         n_total = 0;
  logic [3:0] last_pop;
  logic [1:0] m_prio;
  int         waitc [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one cycle, check the combinational pop, queue the lane expectation,
  // then compare the registered lanes after the edge.
  task automatic apply(input logic rst, input logic [3:0] emp, input logic [3:0] xpop,
                       input logic [1:0] xval, input logic [1:0] xi0, input logic [1:0] xi1,
                       input logic [1:0] xprio);
    exp_t e;
    exp_t g;
    @(negedge clk_i);
    rst_i   = rst;
    empty_i = emp;
    for (int i = 0; i < 4; i++) element_i[i] = 8'($urandom);
    #1;
    last_pop = pop_o;
    chk("pop_o", {28'd0, pop_o}, {28'd0, xpop});
    e.valid   = xval;
    e.idx[0]  = xi0;
    e.idx[1]  = xi1;
    e.elem[0] = xval[0] ? element_i[xi0] : 8'h00;
    e.elem[1] = xval[1] ? element_i[xi1] : 8'h00;
    e.prio    = xprio;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    g = sb_q.pop_front();
    chk("valid_o",  {30'd0, valid_o},        {30'd0, g.valid});
    chk("grant0",   {30'd0, grant_idx_o[0]}, {30'd0, g.idx[0]});
    chk("grant1",   {30'd0, grant_idx_o[1]}, {30'd0, g.idx[1]});
    chk("element0", {24'd0, element_o[0]},   {24'd0, g.elem[0]});
    chk("element1", {24'd0, element_o[1]},   {24'd0, g.elem[1]});
    chk("prio_o",   {30'd0, prio_o},         {30'd0, g.prio});
  endtask

  // Reference: circular scan from the pointer, first two non-empty heads win.
  task automatic model(input logic rst, input logic [3:0] emp, output logic [3:0] pop,
                       output logic [1:0] val, output logic [1:0] i0, output logic [1:0] i1,
                       output logic [1:0] prio);
    int n;
    int j;
    int last;
    pop = '0; val = '0; i0 = '0; i1 = '0; n = 0; last = 0;
    if (rst) m_prio = 2'd0;
    else begin
      for (int off = 0; off < 4; off++) begin
        j = (int'(m_prio) + off) % 4;
        if (!emp[j] && n < 2) begin
          pop[j] = 1'b1;
          if (n == 0) i0 = 2'(j); else i1 = 2'(j);
          val[n] = 1'b1;
          n++;
          last = j;
        end
      end
      if (n > 0) m_prio = 2'((last + 1) % 4);
    end
    prio = m_prio;
  endtask

  vec_t tbl [20];

  initial begin
    logic [3:0] emp, xpop;
    logic [1:0] xval, xi0, xi1, xprio;
    logic       rst;
    int         worst;

    //          rst   empty    pop      valid  i0     i1     prio
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 2'b00, 2'd0, 2'd0, 2'd0};
    tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 2'b00, 2'd0, 2'd0, 2'd0};
    tbl[2]  = '{1'b1, 4'b0000, 4'b0000, 2'b00, 2'd0, 2'd0, 2'd0};
    tbl[3]  = '{1'b0, 4'b0000, 4'b0011, 2'b11, 2'd0, 2'd1, 2'd2};
    tbl[4]  = '{1'b0, 4'b0000, 4'b1100, 2'b11, 2'd2, 2'd3, 2'd0};
    tbl[5]  = '{1'b0, 4'b0000, 4'b0011, 2'b11, 2'd0, 2'd1, 2'd2};
    tbl[6]  = '{1'b0, 4'b0000, 4'b1100, 2'b11, 2'd2, 2'd3, 2'd0};
    tbl[7]  = '{1'b0, 4'b0000, 4'b0011, 2'b11, 2'd0, 2'd1, 2'd2};
    tbl[8]  = '{1'b0, 4'b0101, 4'b1010, 2'b11, 2'd3, 2'd1, 2'd2};
    tbl[9]  = '{1'b0, 4'b1011, 4'b0100, 2'b01, 2'd2, 2'd0, 2'd3};
    tbl[10] = '{1'b0, 4'b1111, 4'b0000, 2'b00, 2'd0, 2'd0, 2'd3};
    tbl[11] = '{1'b0, 4'b1111, 4'b0000, 2'b00, 2'd0, 2'd0, 2'd3};
    tbl[12] = '{1'b0, 4'b1111, 4'b0000, 2'b00, 2'd0, 2'd0, 2'd3};
    tbl[13] = '{1'b0, 4'b1111, 4'b0000, 2'b00, 2'd0, 2'd0, 2'd3};
    tbl[14] = '{1'b0, 4'b1111, 4'b0000, 2'b00, 2'd0, 2'd0, 2'd3};
    tbl[15] = '{1'b0, 4'b0000, 4'b1001, 2'b11, 2'd3, 2'd0, 2'd1};
    tbl[16] = '{1'b1, 4'b0000, 4'b0000, 2'b00, 2'd0, 2'd0, 2'd0};
    tbl[17] = '{1'b0, 4'b0000, 4'b0011, 2'b11, 2'd0, 2'd1, 2'd2};
    tbl[18] = '{1'b0, 4'b0100, 4'b1001, 2'b11, 2'd3, 2'd0, 2'd1};
    tbl[19] = '{1'b0, 4'b1110, 4'b0001, 2'b01, 2'd0, 2'd0, 2'd1};

    for (int v = 0; v < 20; v++)
      apply(tbl[v].rst, tbl[v].empty, tbl[v].pop, tbl[v].valid, tbl[v].i0, tbl[v].i1, tbl[v].prio);

    // Random traffic with occasional resets; fairness tracked from the DUT's pops.
    m_prio = 2'd1;
    for (int i = 0; i < 4; i++) waitc[i] = 0;
    for (int c = 0; c < 1000; c++) begin
      rst = ($urandom_range(99) == 0);
      emp = 4'($urandom) & 4'($urandom);
      model(rst, emp, xpop, xval, xi0, xi1, xprio);
      apply(rst, emp, xpop, xval, xi0, xi1, xprio);
      worst = 0;
      for (int i = 0; i < 4; i++) begin
        if (rst || emp[i] || last_pop[i]) waitc[i] = 0;
        else waitc[i]++;
        if (waitc[i] > worst) worst = waitc[i];
      end
      chk("starvation_wait", 32'(worst < 2), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
